// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default data-memory geometry and the state
// encoding of the data-memory responder.
package cpu_pkg;

    // Default word-address width of the data memory (2**6 = 64 words).
    localparam int DMEM_DEPTH_LOG2 = 6;

    // Default data word width.
    localparam int DMEM_WIDTH = 32;

    // Responder FSM: CLEAR while the array is being initialised (or for the
    // single settle cycle after reset), READY once loads/stores are served.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dmem_state_e;

endpackage : cpu_pkg

// File: rtl/dmem_array.sv
// Data-memory storage: one synchronous write port, one asynchronous read
// port. All arbitration between the clear sweep and committed stores is
// done by the caller; this block just stores what it is told to.
module dmem_array #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Single write port, written on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port is combinational so a load returns data in the same cycle.
    assign rdata_o = mem_q[raddr_i];

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU memory stage.
//
// After reset the block sits in CLEAR; when the DMEM_CLEAR_EN macro is
// defined it sweeps every word to zero (one word per cycle) before going
// READY, otherwise it spends a single cycle in CLEAR and leaves the array
// contents alone.
//
// Stores are posted through a one-entry buffer: a store presented in cycle N
// sits in the buffer during cycle N+1 and is committed to the array at the
// edge ending cycle N+1. Loads that hit the buffered address are forwarded
// from the buffer, so a load sees a store from the cycle after it was issued.
// A load and a store to the same address in the same cycle return the old
// value (read-before-write).
//
// Handshake: dmem_ready is a level, not a pulse. While it is low, dmem_rdata
// is 0 and dmem_w_en is ignored (those stores are dropped, never queued).
// While it is high, every cycle with dmem_w_en=1 is one accepted store and
// dmem_rdata is valid load data for the current dmem_addr.
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int WIDTH      = DMEM_WIDTH,
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DEPTH_LOG2-1:0] dmem_addr,
    input  logic                  dmem_w_en,
    input  logic [WIDTH-1:0]      dmem_wdata,
    output logic [WIDTH-1:0]      dmem_rdata,
    output logic                  dmem_ready,
    output dmem_state_e           dbg_state_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dmem_state_e           state_q;
    logic                  ready_q;

    logic                  pend_valid_q;
    logic                  pend_valid_d;
    logic [DEPTH_LOG2-1:0] pend_addr_q;
    logic [DEPTH_LOG2-1:0] pend_addr_d;
    logic [WIDTH-1:0]      pend_data_q;
    logic [WIDTH-1:0]      pend_data_d;

`ifdef DMEM_CLEAR_EN
    // Sweep address; stops at the last word rather than wrapping.
    localparam logic [DEPTH_LOG2-1:0] CNT_LAST = {DEPTH_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2-1:0] CNT_ONE  = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] cnt_q;
    logic [DEPTH_LOG2-1:0] cnt_d;
`endif

    // Array port signals
    logic                  arr_we;
    logic [DEPTH_LOG2-1:0] arr_waddr;
    logic [WIDTH-1:0]      arr_wdata;
    logic [WIDTH-1:0]      arr_rdata;

    // ------------------------------------------------------------------
    // Next-state for the posted-write buffer (and sweep counter).
    // The buffer only loads while READY; in CLEAR stores are dropped.
    // ------------------------------------------------------------------
    // Compute buffer and counter next values.
    always_comb begin
        pend_valid_d = 1'b0;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
`ifdef DMEM_CLEAR_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_READY: begin
                pend_valid_d = dmem_w_en;
                if (dmem_w_en) begin
                    pend_addr_d = dmem_addr;
                    pend_data_d = dmem_wdata;
                end
            end
            ST_CLEAR: begin
`ifdef DMEM_CLEAR_EN
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
`endif
            end
            default: begin
                pend_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM with registered ready output; reset wins over everything and
    // discards any buffered store without committing it.
    // ------------------------------------------------------------------
    // Sequence CLEAR -> READY and update all registered state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            ready_q      <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
`ifdef DMEM_CLEAR_EN
            cnt_q        <= '0;
`endif
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
`ifdef DMEM_CLEAR_EN
            cnt_q        <= cnt_d;
`endif
            case (state_q)
                ST_CLEAR: begin
`ifdef DMEM_CLEAR_EN
                    // Leave once the last word is being written this cycle.
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
`else
                    state_q <= ST_READY;
                    ready_q <= 1'b1;
`endif
                end
                ST_READY: begin
                    state_q <= ST_READY;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Array write port: clear sweep in CLEAR, buffer commit in READY.
    // Gated by reset so a store pending at reset never lands.
    // ------------------------------------------------------------------
    // Select what (if anything) is written to the array this cycle.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = pend_addr_q;
        arr_wdata = pend_data_q;
        if (!reset) begin
            case (state_q)
                ST_CLEAR: begin
`ifdef DMEM_CLEAR_EN
                    arr_we    = 1'b1;
                    arr_waddr = cnt_q;
                    arr_wdata = '0;
`endif
                end
                ST_READY: begin
                    arr_we = pend_valid_q;
                end
                default: begin
                    arr_we = 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .raddr_i (dmem_addr),
        .rdata_o (arr_rdata)
    );

    // ------------------------------------------------------------------
    // Load path: zero while not ready, buffer forwarding on an address hit,
    // otherwise the array. A store presented this cycle is not yet in the
    // buffer, which gives read-before-write for same-cycle load/store.
    // ------------------------------------------------------------------
    // Forwarding mux for load data.
    always_comb begin
        dmem_rdata = '0;
        if (state_q == ST_READY) begin
            if (pend_valid_q && (pend_addr_q == dmem_addr)) begin
                dmem_rdata = pend_data_q;
            end else begin
                dmem_rdata = arr_rdata;
            end
        end
    end

    assign dmem_ready  = ready_q;
    assign dbg_state_o = state_q;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed stores/loads with hand-computed
// expected load data pushed to a queue and checked by a negedge monitor.
// Expectations follow the DMEM_CLEAR_EN build setting.
module tb_dmem_responder;
  import cpu_pkg::*;

  localparam int W  = 32;
  localparam int AW = 6;
`ifdef DMEM_CLEAR_EN
  localparam int CLR_CYCLES = 64;
  localparam bit HAS_CLR    = 1'b1;
`else
  localparam int CLR_CYCLES = 1;
  localparam bit HAS_CLR    = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] dmem_addr = '0;
  logic          dmem_w_en = 1'b0;
  logic [W-1:0]  dmem_wdata = '0;
  logic [W-1:0]  dmem_rdata;
  logic          dmem_ready;
  dmem_state_e   dbg_state;

  always #5 clk = ~clk;

  dmem_responder #(.WIDTH(W), .DEPTH_LOG2(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .dmem_addr   (dmem_addr),
    .dmem_w_en   (dmem_w_en),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         chk_en = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares load data for cycles the driver marked for checking.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL monitor: load presented with empty expected queue");
      end else begin
        logic [W-1:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_ready"}, {31'b0, dmem_ready}, 32'd1);
        check(nm, dmem_rdata, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic chk, input logic [W-1:0] exp, input string nm);
    dmem_w_en  = we;
    dmem_addr  = a;
    dmem_wdata = d;
    chk_en     = chk;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    chk_en    = 1'b0;
    dmem_w_en = 1'b0;
  endtask

  // One-cycle synchronous reset, with post-reset state checks.
  task automatic do_reset(input string nm);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check({nm, "_rst_ready"}, {31'b0, dmem_ready}, 32'd0);
    check({nm, "_rst_state"}, {31'b0, dbg_state}, {31'b0, ST_CLEAR});
    reset = 1'b0;
  endtask

  // Count not-ready cycles after reset release; bounded.
  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      dmem_w_en = 1'b0;
      if (dmem_ready) break;
      n++;
    end
    check({nm, "_clear_cycles"}, n, CLR_CYCLES);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Clear sweep, with a store attempted in the first CLEAR cycle.
    do_reset("init");
    dmem_w_en  = 1'b1;
    dmem_addr  = 6'd10;
    dmem_wdata = 32'h77;
    wait_ready("init");
`ifdef DMEM_CLEAR_EN
    step(0, 6'd63, 0, 1, 32'h0, "clear_addr63");
    step(0, 6'd10, 0, 1, 32'h0, "store_in_clear_dropped");
    step(0, 6'd0,  0, 1, 32'h0, "clear_addr0");
`endif

    // Posted store with forwarding.
    step(1, 6'd5, 32'hDEADBEEF, 0, 0, "");
    step(0, 6'd5, 0, 1, 32'hDEADBEEF, "fwd_addr5");
    step(0, 6'd5, 0, 1, 32'hDEADBEEF, "array_addr5");

    // Same-cycle load and store.
    step(1, 6'd7, 32'h11, 0, 0, "");
    step(0, 6'd0, 0, 0, 0, "");
    step(1, 6'd7, 32'h22, 1, 32'h11, "rbw_cycle_n");
    step(0, 6'd7, 0, 1, 32'h22, "rbw_cycle_n1");
    step(0, 6'd7, 0, 1, 32'h22, "rbw_array");

    // Back-to-back stores, different addresses.
    step(1, 6'd1, 32'hA, 0, 0, "");
    step(1, 6'd2, 32'hB, 0, 0, "");
    step(0, 6'd1, 0, 1, 32'hA, "b2b_addr1");
    step(0, 6'd2, 0, 1, 32'hB, "b2b_addr2");

    // Back-to-back stores, same address: last writer wins.
    step(1, 6'd3, 32'h1, 0, 0, "");
    step(1, 6'd3, 32'h2, 1, 32'h1, "same_addr_first_fwd");
    step(0, 6'd3, 0, 1, 32'h2, "same_addr_last_fwd");
    step(0, 6'd3, 0, 1, 32'h2, "same_addr_array");

    // Reset with a store pending.
    step(1, 6'd9, 32'h33, 0, 0, "");
    step(0, 6'd9, 0, 1, 32'h33, "pre_reset_addr9");
    step(1, 6'd9, 32'h55, 1, 32'h33, "pre_reset_store");
    do_reset("pend");
    wait_ready("pend");
    step(0, 6'd9, 0, 1, HAS_CLR ? 32'h0 : 32'h33, "pend_discarded_addr9");
    step(0, 6'd9, 0, 1, HAS_CLR ? 32'h0 : 32'h33, "pend_discarded_again");

    // Reset at clear cycle 30 restarts the sweep.
    do_reset("mid");
    for (int i = 0; i < 30; i++) step(0, 6'd0, 0, 0, 0, "");
    do_reset("mid2");
    wait_ready("mid2");
    step(0, 6'd5,  0, 1, HAS_CLR ? 32'h0 : 32'hDEADBEEF, "mid_addr5");
    step(0, 6'd2,  0, 1, HAS_CLR ? 32'h0 : 32'hB, "mid_addr2");

    // Drain and report.
    step(0, 6'd0, 0, 0, 0, "");
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_dmem_responder
